// File: rtl/pe_ingress_buffer.sv
// rtl/pe_ingress_buffer.sv - PE injection-port ingress FIFO with out-of-range destination drop
//
// Purpose: accepts {dest, payload} packets from a PE and buffers them in a small FIFO.
//   Buffered packets are presented in order to the first switch stage. A packet whose
//   destination is not below numPE is accepted and then discarded, so a bad traffic
//   pattern can never stall the PE.
// Optional feature macro: INGRESS_STATS_EN (adds saturating forwarded/dropped counters).
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   i_data           packet from PE (dest in [DataWidth+:AddressWidth])
//   i_data_valid     PE packet valid
//   o_data_ready     buffer can accept (depends on registered count only)
//   o_data           registered head packet to switch
//   o_data_valid     registered head valid
//   i_data_ready     switch accepts head
//   o_pkt_count      (INGRESS_STATS_EN) packets forwarded
//   o_drop_count     (INGRESS_STATS_EN) packets dropped
module pe_ingress_buffer #(
  parameter int numPE        = 4,
  parameter int AddressWidth = 2,
  parameter int DataWidth    = 32,
  parameter int TotalWidth   = 35,
  parameter int FifoDepth    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TotalWidth-1:0] i_data,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  output logic [TotalWidth-1:0] o_data,
  output logic                  o_data_valid,
  input  logic                  i_data_ready
`ifdef INGRESS_STATS_EN
  ,
  output logic [15:0]           o_pkt_count,
  output logic [15:0]           o_drop_count
`endif
);

  localparam int PW = $clog2(FifoDepth);
  localparam logic [PW:0] CountFull = (PW+1)'(FifoDepth);

  logic [TotalWidth-1:0] r_mem [FifoDepth];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW:0]           r_count;
  logic [TotalWidth-1:0] r_data;
  logic                  r_data_valid;

  logic [AddressWidth-1:0] w_dest;
  logic                    w_legal;
  logic                    w_accept;
  logic                    w_push;
  logic                    w_pop;
  logic [PW-1:0]           w_wr_nxt;
  logic [PW-1:0]           w_rd_nxt;
  logic [PW:0]             w_count_nxt;
  logic [TotalWidth-1:0]   w_head_nxt;

  assign w_dest       = i_data[DataWidth +: AddressWidth];
  assign w_legal      = (32'(w_dest) < numPE);
  assign o_data_ready = (r_count != CountFull);
  assign w_accept     = i_data_valid & o_data_ready;
  assign w_push       = w_accept & w_legal;
  assign w_pop        = r_data_valid & i_data_ready;

  assign w_wr_nxt = r_wr_ptr + PW'(w_push);
  assign w_rd_nxt = r_rd_ptr + PW'(w_pop);

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // The next head is the incoming packet when it lands exactly at the next read slot
  // (empty FIFO, or the last entry being popped); memory is not yet written then.
  assign w_head_nxt = (w_push && (w_rd_nxt == r_wr_ptr)) ? i_data : r_mem[w_rd_nxt];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_wr_ptr     <= w_wr_nxt;
      r_rd_ptr     <= w_rd_nxt;
      r_count      <= w_count_nxt;
      r_data       <= w_head_nxt;
      r_data_valid <= (w_count_nxt != '0);
    end
  end

  assign o_data       = r_data;
  assign o_data_valid = r_data_valid;

`ifdef INGRESS_STATS_EN
  logic [15:0] r_pkt_count;
  logic [15:0] r_drop_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_count  <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_pop && (r_pkt_count != 16'hFFFF)) begin
        r_pkt_count <= r_pkt_count + 16'd1;
      end
      if (w_accept && !w_legal && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  assign o_pkt_count  = r_pkt_count;
  assign o_drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_pe_ingress_buffer.sv
// tb/tb_pe_ingress_buffer.sv - directed and randomized self-checking bench for pe_ingress_buffer
module tb_pe_ingress_buffer;

  localparam int TW = 35;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [TW-1:0] i_data = '0;
  logic          i_data_valid = 1'b0;
  logic          o_data_ready;
  logic [TW-1:0] o_data;
  logic          o_data_valid;
  logic          i_data_ready = 1'b0;
`ifdef INGRESS_STATS_EN
  logic [15:0]   o_pkt_count;
  logic [15:0]   o_drop_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pe_ingress_buffer #(
    .numPE(3), .AddressWidth(2), .DataWidth(32), .TotalWidth(35), .FifoDepth(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_data(i_data),
    .i_data_valid(i_data_valid),
    .o_data_ready(o_data_ready),
    .o_data(o_data),
    .o_data_valid(o_data_valid),
    .i_data_ready(i_data_ready)
`ifdef INGRESS_STATS_EN
    ,
    .o_pkt_count(o_pkt_count),
    .o_drop_count(o_drop_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_data_valid = 1'b0;
    i_data_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; returns at a negedge after the packet has been accepted.
  task automatic send(input logic [TW-1:0] pkt, output bit ok);
    bit acc;
    ok = 1'b0;
    i_data = pkt;
    i_data_valid = 1'b1;
    for (int w = 0; w < 100; w++) begin
      acc = o_data_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    i_data_valid = 1'b0;
  endtask

  logic [TW-1:0] q_exp[$];
  bit            prod_done;
  int            n_legal;
  int            n_recv;

  initial begin
    bit ok;
    int k;
    int vcnt;
    logic [TW-1:0] exp5 [5];

    // Test 1: reset state and single-packet latency
    rst = 1'b1;
    @(negedge clk);
    check("rst_valid", 64'(o_data_valid), 64'd0);
    check("rst_data", 64'(o_data), 64'd0);
    check("rst_ready", 64'(o_data_ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    i_data_ready = 1'b1;
    send(35'h0_0000_0007, ok);
    check("t1_valid", 64'(o_data_valid), 64'd1);
    check("t1_data", 64'(o_data), 64'h7);
    @(negedge clk);
    check("t1_empty", 64'(o_data_valid), 64'd0);

    // Test 2: fill to full, hold 5th, drain in order
    do_reset();
    for (int p = 1; p <= 4; p++) begin
      send(TW'(p), ok);
      check("t2_acc", 64'(ok), 64'd1);
    end
    check("t2_full_ready", 64'(o_data_ready), 64'd0);
    check("t2_head", 64'(o_data), 64'd1);
    i_data = 35'd5;
    i_data_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("t2_hold_ready", 64'(o_data_ready), 64'd0);
    for (int p = 0; p < 5; p++) exp5[p] = TW'(p + 1);
    i_data_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      bit acc;
      acc = i_data_valid & o_data_ready;
      if (o_data_valid) begin
        if (k < 5) check("t2_order", 64'(o_data), 64'(exp5[k]));
        k++;
      end
      @(posedge clk);
      @(negedge clk);
      if (acc) i_data_valid = 1'b0;
    end
    check("t2_count", 64'(k), 64'd5);

    // Test 3: simultaneous push and pop at count 2
    do_reset();
    send(35'h0_0000_00A1, ok);
    send(35'h0_0000_00B2, ok);
    check("t3_ready2", 64'(o_data_ready), 64'd1);
    i_data = 35'h0_0000_00C3;
    i_data_valid = 1'b1;
    i_data_ready = 1'b1;
    @(negedge clk);
    i_data_valid = 1'b0;
    check("t3_ready", 64'(o_data_ready), 64'd1);
    check("t3_head_b", 64'(o_data), 64'hB2);
    @(negedge clk);
    check("t3_head_c", 64'(o_data), 64'hC3);
    check("t3_valid_c", 64'(o_data_valid), 64'd1);
    @(negedge clk);
    check("t3_empty", 64'(o_data_valid), 64'd0);

    // Test 4: out-of-range destination dropped (numPE=3)
    do_reset();
    i_data_ready = 1'b1;
    check("t4_ready", 64'(o_data_ready), 64'd1);
    send(35'h3_0000_0009, ok);
    check("t4_acc", 64'(ok), 64'd1);
    check("t4_no_emit", 64'(o_data_valid), 64'd0);
    @(negedge clk);
    check("t4_no_emit2", 64'(o_data_valid), 64'd0);
`ifdef INGRESS_STATS_EN
    check("t4_drop_cnt", 64'(o_drop_count), 64'd1);
`endif
    send(35'h2_0000_000A, ok);
    check("t4_fwd_valid", 64'(o_data_valid), 64'd1);
    check("t4_fwd_data", 64'(o_data), 64'h2_0000_000A);
    @(negedge clk);
    check("t4_fwd_done", 64'(o_data_valid), 64'd0);
`ifdef INGRESS_STATS_EN
    check("t4_pkt_cnt", 64'(o_pkt_count), 64'd1);
`endif

    // Test 5: asynchronous reset mid-cycle discards buffered packets
    do_reset();
    send(35'h0_0000_0011, ok);
    send(35'h1_0000_0022, ok);
    send(35'h2_0000_0033, ok);
    check("t5_pre_valid", 64'(o_data_valid), 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_valid", 64'(o_data_valid), 64'd0);
    check("t5_rst_ready", 64'(o_data_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    i_data_ready = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (o_data_valid) vcnt++;
    end
    check("t5_no_emit", 64'(vcnt), 64'd0);

    // Test 6: random traffic, 1000 packets
    do_reset();
    q_exp.delete();
    prod_done = 1'b0;
    n_legal = 0;
    n_recv = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [TW-1:0] pkt;
          pkt = {1'($urandom), 2'($urandom_range(0, 3)), 32'($urandom)};
          repeat ($urandom_range(0, 2)) @(negedge clk);
          i_data = pkt;
          i_data_valid = 1'b1;
          ok = 1'b0;
          for (int w = 0; w < 200; w++) begin
            bit acc;
            acc = o_data_ready;
            if (acc && (pkt[33:32] < 2'd3)) begin
              q_exp.push_back(pkt);
              n_legal++;
            end
            @(posedge clk);
            @(negedge clk);
            if (acc) begin
              ok = 1'b1;
              break;
            end
          end
          i_data_valid = 1'b0;
          if (!ok) begin
            check("t6_accept_timeout", 64'd0, 64'd1);
            break;
          end
        end
        prod_done = 1'b1;
      end
      begin
        for (int c = 0; c < 20000; c++) begin
          bit popped;
          logic [TW-1:0] got;
          if (prod_done && (n_recv == n_legal)) break;
          i_data_ready = 1'($urandom);
          popped = o_data_valid & i_data_ready;
          got = o_data;
          @(posedge clk);
          if (popped) begin
            if (q_exp.size() == 0) begin
              check("t6_unexpected", 64'(got), 64'd0 - 64'd1);
            end else begin
              check("t6_data", 64'(got), 64'(q_exp.pop_front()));
            end
            n_recv++;
          end
          @(negedge clk);
        end
      end
    join
    check("t6_recv_count", 64'(n_recv), 64'(n_legal));
    check("t6_leftover", 64'(q_exp.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
